// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sqrt engine dispatcher.
// Imported by the interface, the request FIFO and the dispatcher top.
package sqrt_pkg;

  localparam int SQRT_WIDTH = 8;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_SPURIOUS = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/sqrt_dispatch_if.sv
// Request, result and engine handshakes of the sqrt dispatcher.
// master is the dispatcher side, slave is the environment side.
interface sqrt_dispatch_if
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_rad;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_rad;
  logic [WIDTH-1:0] out_root;
  logic [WIDTH-1:0] out_rem;

  logic             eng_start;
  logic [WIDTH-1:0] eng_rad;
  logic             eng_busy;
  logic             eng_valid;
  logic [WIDTH-1:0] eng_root;
  logic [WIDTH-1:0] eng_rem;

  modport master (
    input  in_valid, in_rad,
    output in_ready,
    output out_valid, out_rad,
    output out_root, out_rem,
    input  out_ready,
    output eng_start, eng_rad,
    input  eng_busy, eng_valid,
    input  eng_root, eng_rem
  );

  modport slave (
    output in_valid, in_rad,
    input  in_ready,
    input  out_valid, out_rad,
    input  out_root, out_rem,
    output out_ready,
    input  eng_start, eng_rad,
    output eng_busy, eng_valid,
    output eng_root, eng_rem
  );

endinterface

// File: rtl/sqrt_req_fifo.sv
// Radicand request FIFO; power-of-two depth, wrapping pointers.
// Head data is read combinationally from the read pointer.
module sqrt_req_fifo
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [LW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)
        cnt <= cnt + LW'(1);
      else if (pop && !push)
        cnt <= cnt - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;

endmodule

// File: rtl/sqrt_dispatch.sv
// Feeds queued radicands to the sqrt engine one at a time and
// presents tagged results; watches the engine for hangs.
module sqrt_dispatch
  import sqrt_pkg::*;
#(
  parameter int WIDTH   = SQRT_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sqrt_dispatch_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [1:0]                 err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           state, nxt;
  logic             push, pop, full, empty;
  logic             wd_exp, spur, tmo, cap;
  logic             stale, start_q;
  logic [WIDTH-1:0] head, rad_q;
  logic [WIDTH-1:0] o_rad, o_root, o_rem;
  logic [WW-1:0]    wd;
  logic [1:0]       err_q;

  sqrt_req_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_rad),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign push         = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign wd_exp       = (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (!empty && !bus.eng_busy) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (bus.eng_valid) nxt = HOLD;
             else if (wd_exp)   nxt = IDLE;
      HOLD:  if (bus.out_ready) nxt = IDLE;
    endcase
  end

  // A result arriving before the first start after reset belongs to
  // work dropped by that reset, so it is absorbed without an error.
  always_comb begin
    pop           = (state == ISSUE);
    cap           = (state == WAIT) && bus.eng_valid;
    tmo           = (state == WAIT) && !bus.eng_valid && wd_exp;
    spur          = (state != WAIT) && bus.eng_valid && !stale;
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      rad_q   <= '0;
      wd      <= '0;
      o_rad   <= '0;
      o_root  <= '0;
      o_rem   <= '0;
      err_q   <= '0;
      stale   <= 1'b1;
    end else begin
      start_q <= (nxt == ISSUE);
      if (nxt == ISSUE) rad_q <= head;
      wd <= (state == WAIT) ? wd + WW'(1) : '0;
      if (cap) begin
        o_rad  <= rad_q;
        o_root <= bus.eng_root;
        o_rem  <= bus.eng_rem;
      end
      if (tmo)  err_q[ERR_TIMEOUT]  <= 1'b1;
      if (spur) err_q[ERR_SPURIOUS] <= 1'b1;
      if (pop || bus.eng_valid) stale <= 1'b0;
    end
  end

  assign bus.eng_start = start_q;
  assign bus.eng_rad   = rad_q;
  assign bus.out_rad   = o_rad;
  assign bus.out_root  = o_root;
  assign bus.out_rem   = o_rem;
  assign err           = err_q;

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Self-checking bench for sqrt_dispatch with a behavioural engine
// and an in-order result model built from integer square roots.
module tb_sqrt_dispatch;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TO  = 64;
  localparam int LW  = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic [LW-1:0] level;
  logic [1:0]    err;

  sqrt_dispatch_if #(.WIDTH(W)) bus ();

  sqrt_dispatch #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .level (level),
    .err   (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];

  int  cnt = 0;
  int  lat = 4;
  bit  eng_en = 1;
  bit  force_busy = 0;
  bit  inject = 0;
  bit  rmode = 0;
  logic [W-1:0] erad;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [W-1:0] x);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_rad   = x;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("push_bound", 32'(bus.in_ready), 1);
    else exp_q.push_back(x);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},
          {8'h0, bus.out_rad, bus.out_root, bus.out_rem}, 0);
    check({tag, "_eng_start"}, 32'(bus.eng_start), 0);
    check({tag, "_eng_rad"}, 32'(bus.eng_rad), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Behavioural engine: answers a start after lat cycles.
  assign bus.eng_busy = force_busy | (cnt != 0);

  initial begin
    bus.eng_valid = 1'b0;
    bus.eng_root  = '0;
    bus.eng_rem   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_valid = 1'b0;
      if (inject) begin
        bus.eng_valid = 1'b1;
        bus.eng_root  = 8'hAA;
        bus.eng_rem   = 8'h55;
        inject = 0;
      end
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.eng_valid = 1'b1;
          bus.eng_root  = W'(isqrt(int'(erad)));
          bus.eng_rem   = W'(int'(erad) - isqrt(int'(erad)) ** 2);
        end
      end
      if (bus.eng_start && eng_en) begin
        cnt  = lat;
        erad = bus.eng_rad;
      end
    end
  end

  // Result scoreboard: each accepted result must match the oldest
  // outstanding radicand and its integer square root.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(bus.out_valid), 0);
      end else begin
        logic [W-1:0] r;
        int rt;
        r  = exp_q.pop_front();
        rt = isqrt(int'(r));
        check("out_rad", 32'(bus.out_rad), 32'(r));
        check("out_root", 32'(bus.out_root), 32'(rt));
        check("out_rem", 32'(bus.out_rem), 32'(int'(r) - rt * rt));
      end
    end
  end

  initial begin
    int n;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_rad    = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single request, 4-cycle engine
    bus.in_valid = 1'b1;
    bus.in_rad   = 8'd50;
    exp_q.push_back(8'd50);
    tick();
    bus.in_valid = 1'b0;
    check("single_start_early", 32'(bus.eng_start), 0);
    check("single_level", 32'(level), 1);
    tick();
    check("single_start", 32'(bus.eng_start), 1);
    check("single_eng_rad", 32'(bus.eng_rad), 50);
    tick();
    check("single_start_pulse", 32'(bus.eng_start), 0);
    check("single_level_pop", 32'(level), 0);
    drain(30);
    check("single_err", 32'(err), 0);

    // back-pressure with a stalled consumer
    bus.out_ready = 1'b0;
    push(8'd0);
    push(8'd1);
    push(8'd4);
    push(8'd255);
    push(8'd100);
    repeat (10) tick();
    check("bp_level_full", 32'(level), 4);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    check("bp_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    drain(200);
    check("bp_level_empty", 32'(level), 0);

    // engine busy holds off the start
    force_busy = 1;
    push(8'd9);
    n = 0;
    repeat (10) begin
      if (bus.eng_start) n++;
      tick();
    end
    check("busy_no_start", n, 0);
    force_busy = 0;
    check("busy_start_low", 32'(bus.eng_start), 0);
    tick();
    check("busy_start", 32'(bus.eng_start), 1);
    check("busy_eng_rad", 32'(bus.eng_rad), 9);
    tick();
    check("busy_start_pulse", 32'(bus.eng_start), 0);
    drain(30);

    // engine hang: first request times out, next one completes
    eng_en = 0;
    push(8'd77);
    push(8'd88);
    n = 0;
    while (!bus.eng_start && n < 20) begin
      tick();
      n++;
    end
    check("to_start_seen", 32'(bus.eng_start), 1);
    repeat (TO) tick();
    check("to_err_before", 32'(err[0]), 0);
    tick();
    check("to_err_set", 32'(err[0]), 1);
    eng_en = 1;
    void'(exp_q.pop_front());
    drain(40);
    check("to_err_final", 32'(err), 1);

    // spurious engine result while idle
    force_busy = 1;
    push(8'd5);
    check("sp_level_before", 32'(level), 1);
    inject = 1;
    tick();
    tick();
    tick();
    check("sp_err", 32'(err), 3);
    check("sp_out_valid", 32'(bus.out_valid), 0);
    check("sp_level_after", 32'(level), 1);
    force_busy = 0;
    drain(40);

    // random traffic with random engine latency and consumer stalls
    rmode = 1;
    for (int i = 0; i < 30; i++) begin
      lat = $urandom_range(1, 8);
      repeat ($urandom_range(0, 3)) tick();
      push(W'($urandom));
    end
    rmode = 0;
    bus.out_ready = 1'b1;
    drain(600);
    check("rand_err", 32'(err), 3);

    // reset during WAIT with three requests queued
    lat = 20;
    push(8'd11);
    push(8'd22);
    push(8'd33);
    push(8'd44);
    tick();
    tick();
    check("rst_level_before", 32'(level), 3);
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outs("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_level_after", 32'(level), 0);
    repeat (25) tick();
    check("rst_late_err", 32'(err), 0);
    check("rst_late_out_valid", 32'(bus.out_valid), 0);
    check("rst_late_start", 32'(bus.eng_start), 0);

    // normal service after reset
    lat = 3;
    push(8'd16);
    drain(30);
    check("post_rst_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
